// File: rtl/store_narrow_rmw_if.sv
// Store request / data-RAM bundle for store_narrow_rmw.
//   master : CPU + RAM side (drives request fields and mem_rdata)
//   slave  : store_narrow_rmw (drives ready/busy/done and RAM address/write)
// Optional: `MISALIGN_TRAP_EN adds the misalign status line.
interface store_narrow_rmw_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        st_type;
  logic [31:0]       byte_addr;
  logic [31:0]       wdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              busy;
  logic              done;
`ifdef MISALIGN_TRAP_EN
  logic              misalign;

  modport master (
    output req_valid, st_type, byte_addr, wdata, mem_rdata,
    input  req_ready, mem_addr, mem_we, mem_wdata, busy, done, misalign
  );

  modport slave (
    input  req_valid, st_type, byte_addr, wdata, mem_rdata,
    output req_ready, mem_addr, mem_we, mem_wdata, busy, done, misalign
  );
`else
  modport master (
    output req_valid, st_type, byte_addr, wdata, mem_rdata,
    input  req_ready, mem_addr, mem_we, mem_wdata, busy, done
  );

  modport slave (
    input  req_valid, st_type, byte_addr, wdata, mem_rdata,
    output req_ready, mem_addr, mem_we, mem_wdata, busy, done
  );
`endif
endinterface

// File: rtl/store_narrow_rmw.sv
// Narrowing store unit: writes sw/sh/sb stores into a word-addressed
// synchronous RAM, using read-modify-write for sub-word stores.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : store_narrow_rmw_if.slave (request handshake, RAM port,
//                busy/done status)
// Optional feature macro: MISALIGN_TRAP_EN (misaligned sw/sh are trapped
// with misalign+done instead of being written).
module store_narrow_rmw #(
  parameter int unsigned ADDR_W = 10
) (
  input logic                clk,
  input logic                rst_n,
  store_narrow_rmw_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state;
  logic [1:0]        st_q;
  logic [1:0]        addr_lo_q;
  logic [31:0]       wdata_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_we_q;
  logic              req_ready_q;
  logic              busy_q;
  logic              done_q;
  logic [31:0]       merged;
  logic              is_word;
  logic              unused_addr_hi;

  // Reserved type 11 behaves as a full-word store.
  assign is_word = (bus.st_type == 2'b00) || (bus.st_type == 2'b11);

  // Byte-address bits above the RAM word index are not used.
  assign unused_addr_hi = ^bus.byte_addr[31:ADDR_W+2];

`ifdef MISALIGN_TRAP_EN
  logic misalign_q;
  logic is_misaligned;

  assign is_misaligned = (bus.st_type == 2'b01) ? bus.byte_addr[0]
                       : (bus.st_type == 2'b10) ? 1'b0
                       : (bus.byte_addr[1:0] != 2'b00);
  assign bus.misalign  = misalign_q;
`endif

  // Control FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      st_q        <= 2'b00;
      addr_lo_q   <= 2'b00;
      wdata_q     <= 32'd0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misalign_q  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            st_q        <= bus.st_type;
            addr_lo_q   <= bus.byte_addr[1:0];
            wdata_q     <= bus.wdata;
            mem_addr_q  <= bus.byte_addr[ADDR_W+1:2];
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
`ifdef MISALIGN_TRAP_EN
            if (is_misaligned) begin
              state      <= DONE;
              done_q     <= 1'b1;
              misalign_q <= 1'b1;
            end else
`endif
            if (is_word) begin
              state    <= WRITE;
              mem_we_q <= 1'b1;
            end else begin
              state <= READ;
            end
          end
        end
        READ: begin
          state    <= WRITE;
          mem_we_q <= 1'b1;
        end
        WRITE: begin
          state    <= DONE;
          mem_we_q <= 1'b0;
          done_q   <= 1'b1;
        end
        default: begin
          state       <= IDLE;
          done_q      <= 1'b0;
          req_ready_q <= 1'b1;
          busy_q      <= 1'b0;
`ifdef MISALIGN_TRAP_EN
          misalign_q  <= 1'b0;
`endif
        end
      endcase
    end
  end

  // Lane merge of new data into the word read back during WRITE.
  always_comb begin
    merged = wdata_q;
    case (st_q)
      2'b01: begin
        if (addr_lo_q[1]) merged = {wdata_q[15:0], bus.mem_rdata[15:0]};
        else              merged = {bus.mem_rdata[31:16], wdata_q[15:0]};
      end
      2'b10: begin
        merged = bus.mem_rdata;
        case (addr_lo_q)
          2'd0:    merged[7:0]   = wdata_q[7:0];
          2'd1:    merged[15:8]  = wdata_q[7:0];
          2'd2:    merged[23:16] = wdata_q[7:0];
          default: merged[31:24] = wdata_q[7:0];
        endcase
      end
      default: merged = wdata_q;
    endcase
  end

  assign bus.mem_wdata = (state == WRITE) ? merged : 32'd0;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.req_ready = req_ready_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_store_narrow_rmw.sv
// Randomized self-checking bench for store_narrow_rmw with a behavioural
// RAM and a byte-lane reference model of memory contents and latency.
module tb_store_narrow_rmw;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  logic [31:0] ram     [DEPTH];
  logic [31:0] ref_mem [DEPTH];

  store_narrow_rmw_if #(.ADDR_W(ADDR_W)) bus ();

  store_narrow_rmw #(.ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous read-first data RAM.
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Expected word after a store, from byte-lane arithmetic.
  function automatic logic [31:0] ref_merge(input logic [1:0] t, input logic [31:0] a,
                                            input logic [31:0] d, input logic [31:0] old);
    int          sh;
    logic [31:0] mask;
    case (t)
      2'd1: begin sh = 16 * int'(a[1]);   mask = 32'h0000_FFFF << sh; end
      2'd2: begin sh = 8 * int'(a[1:0]);  mask = 32'h0000_00FF << sh; end
      default: return d;
    endcase
    return (old & ~mask) | ((d << sh) & mask);
  endfunction

  function automatic bit ref_misaligned(input logic [1:0] t, input logic [31:0] a);
`ifdef MISALIGN_TRAP_EN
    if (t == 2'd1) return a[0];
    if (t == 2'd2) return 1'b0;
    return a[1:0] != 2'b00;
`else
    return (t != t) && (a != a);
`endif
  endfunction

  task automatic ref_apply(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d);
    int w;
    w = int'(a[ADDR_W+1:2]);
    if (!ref_misaligned(t, a)) ref_mem[w] = ref_merge(t, a, d, ref_mem[w]);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (!bus.req_ready && k < 10) begin
      @(negedge clk);
      k++;
    end
    if (!bus.req_ready) check("idle_timeout", 32'(bus.req_ready), 32'd1);
  endtask

  // One store; checks write/done timing, ready during busy, and the word.
  task automatic do_store(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d);
    bit word_t, mis;
    int first_we, we_cnt, first_done, done_cnt, w, exp_we, exp_done;
    logic rdy_bad;
    word_t   = (t == 2'd0) || (t == 2'd3);
    mis      = ref_misaligned(t, a);
    exp_we   = mis ? -1 : (word_t ? 1 : 2);
    exp_done = mis ? 1 : (word_t ? 2 : 3);
    w        = int'(a[ADDR_W+1:2]);
    first_we = -1; we_cnt = 0; first_done = -1; done_cnt = 0; rdy_bad = 1'b0;
    @(negedge clk);
    wait_idle();
    bus.req_valid = 1'b1;
    bus.st_type   = t;
    bus.byte_addr = a;
    bus.wdata     = d;
    ref_apply(t, a, d);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (bus.mem_we) begin
        we_cnt++;
        if (first_we < 0) first_we = c;
      end
      if (bus.done) begin
        done_cnt++;
        if (first_done < 0) first_done = c;
`ifdef MISALIGN_TRAP_EN
        check("misalign_flag", 32'(bus.misalign), 32'(mis));
`endif
      end
      if (c <= exp_done && (bus.req_ready || !bus.busy)) rdy_bad = 1'b1;
    end
    check("we_cycle",   32'(first_we),   32'(exp_we));
    check("we_count",   32'(we_cnt),     mis ? 32'd0 : 32'd1);
    check("done_cycle", 32'(first_done), 32'(exp_done));
    check("done_count", 32'(done_cnt),   32'd1);
    check("ready_busy", 32'(rdy_bad),    32'd0);
    check("ram_word",   ram[w],          ref_mem[w]);
  endtask

  // req_valid held high: two sb requests, accepts must be 4 cycles apart.
  task automatic back_to_back();
    int   acc[$];
    logic rdy_bad;
    rdy_bad = 1'b0;
    @(negedge clk);
    wait_idle();
    bus.req_valid = 1'b1;
    bus.st_type   = 2'd2;
    bus.byte_addr = 32'h0000_001C;
    bus.wdata     = 32'h0000_00A5;
    for (int k = 0; k < 12 && acc.size() < 2; k++) begin
      if (bus.req_ready == bus.busy) rdy_bad = 1'b1;
      if (bus.req_ready) begin
        acc.push_back(k);
        ref_apply(bus.st_type, bus.byte_addr, bus.wdata);
      end
      @(posedge clk);
      #1;
      if (acc.size() == 1 && acc[0] == k) begin
        bus.byte_addr = 32'h0000_001D;
        bus.wdata     = 32'hFFFF_FF5A;
      end
      if (acc.size() == 2) bus.req_valid = 1'b0;
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("b2b_accepts", 32'(acc.size()), 32'd2);
    if (acc.size() == 2) check("b2b_spacing", 32'(acc[1] - acc[0]), 32'd4);
    check("b2b_ready_busy", 32'(rdy_bad), 32'd0);
    check("b2b_ram", ram[7], ref_mem[7]);
  endtask

  // Reset asserted during the READ of an sb: no write, no done.
  task automatic reset_in_read();
    logic saw_we, saw_done;
    saw_we = 1'b0; saw_done = 1'b0;
    ram[9] = 32'hCAFE_F00D; ref_mem[9] = 32'hCAFE_F00D;
    @(negedge clk);
    wait_idle();
    bus.req_valid = 1'b1;
    bus.st_type   = 2'd2;
    bus.byte_addr = 32'h0000_0026;
    bus.wdata     = 32'h0000_0077;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    check("rst_busy_in_read", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    if (bus.mem_we) saw_we = 1'b1;
    rst_n = 1'b1;
    check("rst_ready_after", 32'(bus.req_ready), 32'd1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.mem_we) saw_we = 1'b1;
      if (bus.done)   saw_done = 1'b1;
    end
    check("rst_no_we",   32'(saw_we),   32'd0);
    check("rst_no_done", 32'(saw_done), 32'd0);
    check("rst_ram",     ram[9],        32'hCAFE_F00D);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    bus.st_type   = 2'd0;
    bus.byte_addr = 32'd0;
    bus.wdata     = 32'd0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      ram[i]     = $urandom;
      ref_mem[i] = ram[i];
    end
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_done",      32'(bus.done),      32'd0);
    check("rst_mem_we",    32'(bus.mem_we),    32'd0);
    check("rst_mem_addr",  32'(bus.mem_addr),  32'd0);
    check("rst_mem_wdata", bus.mem_wdata,      32'd0);
`ifdef MISALIGN_TRAP_EN
    check("rst_misalign",  32'(bus.misalign),  32'd0);
`endif
    rst_n = 1'b1;

    ram[5] = 32'h1122_3344; ref_mem[5] = 32'h1122_3344;
    do_store(2'd2, 32'h0000_0016, 32'hFFFF_FFAB);
    check("plan_sb", ram[5], 32'h11AB_3344);
    ram[5] = 32'h1122_3344; ref_mem[5] = 32'h1122_3344;
    do_store(2'd1, 32'h0000_0016, 32'h1234_BEEF);
    check("plan_sh", ram[5], 32'hBEEF_3344);
    do_store(2'd0, 32'h0000_0014, 32'hDEAD_BEEF);
    check("plan_sw", ram[5], 32'hDEAD_BEEF);
    ram[5] = 32'h1122_3344; ref_mem[5] = 32'h1122_3344;
    do_store(2'd1, 32'h0000_0015, 32'h1234_BEEF);
`ifdef MISALIGN_TRAP_EN
    check("plan_sh_mis", ram[5], 32'h1122_3344);
`else
    check("plan_sh_mis", ram[5], 32'h1122_BEEF);
`endif
    do_store(2'd3, 32'h0000_0040, 32'h0BAD_F00D);

    back_to_back();
    reset_in_read();

    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      a = $urandom;
      if (i < 30) a[31:6] = 26'd0;
      do_store(2'($urandom_range(0, 3)), a, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
